// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: frame command encodings and FSM states.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WAIT_TX,
    ST_SEND,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load / serial-in shift register; direction chosen by LSB_FIRST.
module spi_shift_reg #(
  parameter int W         = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] par_o,
  output logic         ser_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_data_i;
    end else if (shift_i) begin
      if (LSB_FIRST != 0) sr_d = {ser_i, sr_q[W-1:1]};
      else                sr_d = {sr_q[W-2:0], ser_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign par_o = sr_q;
  assign ser_o = (LSB_FIRST != 0) ? sr_q[0] : sr_q[W-1];

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave: receives {cmd, payload} frames, answers read-data commands
// with DATA_W bits from a tx producer, flags aborts and out-of-order reads.
module spi_slave_gen
  import spi_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int LSB_FIRST    = 0,
  parameter int CHK_RD_ORDER = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              abort,
  output logic              cmd_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               cmd_err_q, cmd_err_d;
  logic               abort_q, abort_d;

  logic               rx_shift, tx_load, tx_shift, tx_ser;
  logic [FRAME_W-2:0] rx_q;
  logic [FRAME_W-1:0] raw, frame;
  logic [1:0]         frame_cmd;
  logic               rd_ok;
  logic               rx_ser_unused;
  logic [DATA_W-1:0]  tx_par_unused;

  // The rx shifter holds all but the last bit; the last bit is taken live
  // from MOSI so the frame can be registered on the edge that samples it.
  spi_shift_reg #(.W(FRAME_W - 1), .LSB_FIRST(LSB_FIRST)) u_rx_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (rx_shift),
    .ser_i       (MOSI),
    .par_o       (rx_q),
    .ser_o       (rx_ser_unused)
  );

  spi_shift_reg #(.W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_tx_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (tx_load),
    .load_data_i (tx_data),
    .shift_i     (tx_shift),
    .ser_i       (1'b0),
    .par_o       (tx_par_unused),
    .ser_o       (tx_ser)
  );

  // cmd always arrives first (cmd[1] then cmd[0]); only the payload order flips.
  always_comb begin
    if (LSB_FIRST != 0) begin
      raw   = {MOSI, rx_q};
      frame = {raw[0], raw[1], raw[FRAME_W-1:2]};
    end else begin
      raw   = {rx_q, MOSI};
      frame = raw;
    end
    frame_cmd = frame[FRAME_W-1 -: 2];
    rd_ok     = rd_pend_q || (CHK_RD_ORDER == 0);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_pend_d  = rd_pend_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    abort_d    = 1'b0;
    rx_shift   = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!SS_n) begin
          rx_shift = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = ST_RECV;
        end
      end
      ST_RECV: begin
        if (SS_n) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          rx_shift = 1'b1;
          if (cnt_q == RX_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
            if (frame_cmd == CMD_RD_DATA && !rd_ok) begin
              cmd_err_d = 1'b1;
            end else begin
              rx_valid_d = 1'b1;
              rx_data_d  = frame;
              if (frame_cmd == CMD_RD_ADDR) rd_pend_d = 1'b1;
              if (frame_cmd == CMD_RD_DATA) begin
                rd_pend_d = 1'b0;
                state_d   = ST_WAIT_TX;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT_TX: begin
        if (SS_n) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (tx_valid) begin
          tx_load = 1'b1;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (SS_n) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tx_shift = 1'b1;
          if (cnt_q == TX_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (SS_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cmd_err_q  <= cmd_err_d;
      abort_q    <= abort_d;
    end
  end

  assign MISO     = (state_q == ST_SEND) & tx_ser;
  assign tx_ready = (state_q == ST_WAIT_TX);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign cmd_err  = cmd_err_q;
  assign abort    = abort_q;

endmodule
